// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory stage: op encodings, FSM state codes and op decode helpers.
package lsu_pkg;

  localparam logic [3:0] MOP_NONE = 4'd0;
  localparam logic [3:0] MOP_LB   = 4'd1;
  localparam logic [3:0] MOP_LH   = 4'd2;
  localparam logic [3:0] MOP_LW   = 4'd3;
  localparam logic [3:0] MOP_LD   = 4'd4;
  localparam logic [3:0] MOP_LBU  = 4'd5;
  localparam logic [3:0] MOP_LHU  = 4'd6;
  localparam logic [3:0] MOP_LWU  = 4'd7;
  localparam logic [3:0] MOP_SB   = 4'd8;
  localparam logic [3:0] MOP_SH   = 4'd9;
  localparam logic [3:0] MOP_SW   = 4'd10;
  localparam logic [3:0] MOP_SD   = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Access size in bytes; 0 marks pass-through and undefined encodings.
  function automatic logic [3:0] mop_bytes(input logic [3:0] op);
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: return 4'd1;
      MOP_LH, MOP_LHU, MOP_SH: return 4'd2;
      MOP_LW, MOP_LWU, MOP_SW: return 4'd4;
      MOP_LD, MOP_SD:          return 4'd8;
      default:                 return 4'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MOP_LB) && (op <= MOP_LWU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MOP_SB) && (op <= MOP_SD);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op >= MOP_LB) && (op <= MOP_LD);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: selects the addressed lane from an aligned word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [LANE_W-1:0]     lane,
  input  logic [3:0]            op,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  fill;
  int                    nbits;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    nbits   = 8 * int'(mop_bytes(op));
    fill    = 1'b0;
    data    = shifted;
    // Full-width accesses need no extension.
    if (nbits > 0 && nbits < DATA_WIDTH) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (i == nbits - 1) fill = is_signed(op) & shifted[i];
      end
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (i >= nbits) data[i] = fill;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage between execute and writeback: issues dmem requests, aligns load data, flags bad accesses.
// state | meaning:  IDLE empty | REQ request on dmem | WAIT awaiting response | DONE result on wb
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [3:0]                ex_op,
  input  logic [DATA_WIDTH-1:0]     ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_wdata,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_rf_we,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic                      dmem_req_we,
  output logic [DATA_WIDTH-1:0]     dmem_req_addr,
  output logic [STRB_WIDTH-1:0]     dmem_req_wstrb,
  output logic [DATA_WIDTH-1:0]     dmem_req_wdata,
  input  logic                      dmem_rsp_valid,
  output logic                      dmem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]     dmem_rsp_rdata,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic                      wb_rf_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      wb_fault
);

  localparam int LANE_W = $clog2(STRB_WIDTH);

  logic [1:0]                state;
  logic [3:0]                op_q;
  logic [DATA_WIDTH-1:0]     addr_q, wdata_q, data_q;
  logic [STRB_WIDTH-1:0]     strb_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      rf_we_q, fault_q;

  logic                      accept, misaligned, unsupported, fault;
  logic [3:0]                bytes;
  logic [LANE_W-1:0]         lane;
  logic [STRB_WIDTH-1:0]     size_mask;
  logic [DATA_WIDTH-1:0]     load_data;

  assign ex_ready = (state == ST_IDLE) || (state == ST_DONE && wb_ready);
  assign accept   = ex_valid && ex_ready;
  assign lane     = ex_addr[LANE_W-1:0];
  assign bytes    = mop_bytes(ex_op);

  always_comb begin
    misaligned = 1'b0;
    size_mask  = '0;
    case (bytes)
      4'd1: size_mask = STRB_WIDTH'(4'h1);
      4'd2: begin misaligned = ex_addr[0];       size_mask = STRB_WIDTH'(4'h3);  end
      4'd4: begin misaligned = |ex_addr[1:0];    size_mask = STRB_WIDTH'(4'hF);  end
      4'd8: begin misaligned = |ex_addr[2:0];    size_mask = STRB_WIDTH'(8'hFF); end
      default: ;
    endcase
  end

  // Undefined encodings are rejected alongside the ops a 32-bit datapath cannot serve.
  assign unsupported = ((DATA_WIDTH == 32) && (ex_op == MOP_LD || ex_op == MOP_LWU || ex_op == MOP_SD))
                     || (ex_op != MOP_NONE && bytes == 4'd0);
  assign fault       = misaligned || unsupported;

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata (dmem_rsp_rdata),
    .lane  (addr_q[LANE_W-1:0]),
    .op    (op_q),
    .data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= MOP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      rd_q    <= '0;
      rf_we_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (accept) begin
      op_q    <= ex_op;
      addr_q  <= ex_addr;
      wdata_q <= ex_wdata << {lane, 3'b000};
      strb_q  <= is_store(ex_op) ? (size_mask << lane) : '0;
      rd_q    <= ex_rd;
      if (ex_op == MOP_NONE) begin
        state   <= ST_DONE;
        data_q  <= ex_result;
        rf_we_q <= ex_rf_we;
        fault_q <= 1'b0;
      end else if (fault) begin
        state   <= ST_DONE;
        data_q  <= ex_addr;
        rf_we_q <= 1'b0;
        fault_q <= 1'b1;
      end else begin
        state   <= ST_REQ;
        data_q  <= '0;
        rf_we_q <= ex_rf_we && is_load(ex_op);
        fault_q <= 1'b0;
      end
    end else begin
      case (state)
        ST_REQ:  if (dmem_req_ready) state <= ST_WAIT;
        ST_WAIT: if (dmem_rsp_valid) begin
          state  <= ST_DONE;
          data_q <= is_load(op_q) ? load_data : '0;
        end
        ST_DONE: if (wb_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req_valid = (state == ST_REQ);
  assign dmem_req_we    = is_store(op_q);
  assign dmem_req_addr  = {addr_q[DATA_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
  assign dmem_req_wstrb = strb_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_rsp_ready = (state == ST_WAIT);
  assign wb_valid       = (state == ST_DONE);
  assign wb_rf_we       = rf_we_q;
  assign wb_rd          = rd_q;
  assign wb_data        = data_q;
  assign wb_fault       = fault_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a 32-bit and a 64-bit instance share stimulus, each test checks one.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_valid, ex_rf_we, req_ready, rsp_valid, wb_ready;
  logic [3:0]  ex_op;
  logic [63:0] ex_addr, ex_wdata, ex_result, rsp_rdata;
  logic [4:0]  ex_rd;

  logic        ex_ready_32, req_valid_32, req_we_32, rsp_ready_32, wb_valid_32, wb_rf_we_32, wb_fault_32;
  logic [31:0] req_addr_32, req_wdata_32, wb_data_32;
  logic [3:0]  wstrb_32;
  logic [4:0]  wb_rd_32;

  logic        ex_ready_64, req_valid_64, req_we_64, rsp_ready_64, wb_valid_64, wb_rf_we_64, wb_fault_64;
  logic [63:0] req_addr_64, req_wdata_64, wb_data_64;
  logic [7:0]  wstrb_64;
  logic [4:0]  wb_rd_64;

  int checks = 0;
  int fails  = 0;

  lsu_mem_stage #(.DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready_32), .ex_op(ex_op),
    .ex_addr(ex_addr[31:0]), .ex_wdata(ex_wdata[31:0]), .ex_result(ex_result[31:0]),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
    .dmem_req_valid(req_valid_32), .dmem_req_ready(req_ready), .dmem_req_we(req_we_32),
    .dmem_req_addr(req_addr_32), .dmem_req_wstrb(wstrb_32), .dmem_req_wdata(req_wdata_32),
    .dmem_rsp_valid(rsp_valid), .dmem_rsp_ready(rsp_ready_32), .dmem_rsp_rdata(rsp_rdata[31:0]),
    .wb_valid(wb_valid_32), .wb_ready(wb_ready), .wb_rf_we(wb_rf_we_32), .wb_rd(wb_rd_32),
    .wb_data(wb_data_32), .wb_fault(wb_fault_32)
  );

  lsu_mem_stage #(.DATA_WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready_64), .ex_op(ex_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
    .dmem_req_valid(req_valid_64), .dmem_req_ready(req_ready), .dmem_req_we(req_we_64),
    .dmem_req_addr(req_addr_64), .dmem_req_wstrb(wstrb_64), .dmem_req_wdata(req_wdata_64),
    .dmem_rsp_valid(rsp_valid), .dmem_rsp_ready(rsp_ready_64), .dmem_rsp_rdata(rsp_rdata),
    .wb_valid(wb_valid_64), .wb_ready(wb_ready), .wb_rf_we(wb_rf_we_64), .wb_rd(wb_rd_64),
    .wb_data(wb_data_64), .wb_fault(wb_fault_64)
  );

  task automatic apply_reset();
    rst = 1'b1; ex_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; wb_ready = 1'b1;
    ex_op = MOP_NONE; ex_addr = '0; ex_wdata = '0; ex_result = '0; ex_rd = '0; ex_rf_we = 1'b0;
    rsp_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one entry for a single cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] result, input logic [4:0] rd);
    ex_op = op; ex_addr = addr; ex_wdata = wdata; ex_result = result; ex_rd = rd; ex_rf_we = 1'b1;
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  // Zero-stall request, one-cycle response; returns with the result visible on wb.
  task automatic mem_load(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] rdata);
    issue(op, addr, 64'h0, 64'h0, 5'd7);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = rdata;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (ex_ready_32 !== 1'b1) begin fails++; $display("FAIL rst_ex_ready got=%b exp=1", ex_ready_32); end
    checks++; if (wb_valid_32 !== 1'b0) begin fails++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid_32); end
    checks++; if (req_valid_32 !== 1'b0) begin fails++; $display("FAIL rst_req_valid got=%b exp=0", req_valid_32); end
    checks++; if (rsp_ready_32 !== 1'b0) begin fails++; $display("FAIL rst_rsp_ready got=%b exp=0", rsp_ready_32); end
    checks++; if (wb_fault_32 !== 1'b0) begin fails++; $display("FAIL rst_wb_fault got=%b exp=0", wb_fault_32); end
  endtask

  task automatic test_lb();
    issue(MOP_LB, 64'h1003, 64'h0, 64'h0, 5'd5);
    checks++; if (req_valid_32 !== 1'b1) begin fails++; $display("FAIL lb_req_valid got=%b exp=1", req_valid_32); end
    checks++; if (req_addr_32 !== 32'h1000) begin fails++; $display("FAIL lb_req_addr got=%h exp=00001000", req_addr_32); end
    checks++; if (req_we_32 !== 1'b0) begin fails++; $display("FAIL lb_req_we got=%b exp=0", req_we_32); end
    checks++; if (wstrb_32 !== 4'b0000) begin fails++; $display("FAIL lb_wstrb got=%b exp=0000", wstrb_32); end
    checks++; if (ex_ready_32 !== 1'b0) begin fails++; $display("FAIL lb_ex_ready got=%b exp=0", ex_ready_32); end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    checks++; if (rsp_ready_32 !== 1'b1) begin fails++; $display("FAIL lb_rsp_ready got=%b exp=1", rsp_ready_32); end
    rsp_valid = 1'b1; rsp_rdata = 64'h0000_0000_8012_3456;
    @(negedge clk);
    rsp_valid = 1'b0;
    checks++; if (wb_valid_32 !== 1'b1) begin fails++; $display("FAIL lb_wb_valid got=%b exp=1", wb_valid_32); end
    checks++; if (wb_data_32 !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_wb_data got=%h exp=ffffff80", wb_data_32); end
    checks++; if (wb_rf_we_32 !== 1'b1) begin fails++; $display("FAIL lb_wb_rf_we got=%b exp=1", wb_rf_we_32); end
    checks++; if (wb_rd_32 !== 5'd5) begin fails++; $display("FAIL lb_wb_rd got=%0d exp=5", wb_rd_32); end
    @(negedge clk);
    checks++; if (wb_valid_32 !== 1'b0) begin fails++; $display("FAIL lb_wb_drain got=%b exp=0", wb_valid_32); end
  endtask

  task automatic test_lhu();
    mem_load(MOP_LHU, 64'h1002, 64'h0000_0000_8012_3456);
    checks++; if (wb_data_32 !== 32'h0000_8012) begin fails++; $display("FAIL lhu_wb_data got=%h exp=00008012", wb_data_32); end
    checks++; if (wb_fault_32 !== 1'b0) begin fails++; $display("FAIL lhu_wb_fault got=%b exp=0", wb_fault_32); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    issue(MOP_LH, 64'h1001, 64'h0, 64'h0, 5'd3);
    checks++; if (wb_valid_32 !== 1'b1) begin fails++; $display("FAIL mis_wb_valid got=%b exp=1", wb_valid_32); end
    checks++; if (wb_fault_32 !== 1'b1) begin fails++; $display("FAIL mis_wb_fault got=%b exp=1", wb_fault_32); end
    checks++; if (wb_rf_we_32 !== 1'b0) begin fails++; $display("FAIL mis_wb_rf_we got=%b exp=0", wb_rf_we_32); end
    checks++; if (wb_data_32 !== 32'h1001) begin fails++; $display("FAIL mis_wb_data got=%h exp=00001001", wb_data_32); end
    checks++; if (req_valid_32 !== 1'b0) begin fails++; $display("FAIL mis_req_valid got=%b exp=0", req_valid_32); end
    @(negedge clk);
    checks++; if (req_valid_32 !== 1'b0) begin fails++; $display("FAIL mis_req_after got=%b exp=0", req_valid_32); end
  endtask

  task automatic test_store_stall();
    issue(MOP_SH, 64'h2002, 64'hABCD, 64'h0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_valid_32 !== 1'b1) begin fails++; $display("FAIL sh_req_valid[%0d] got=%b exp=1", i, req_valid_32); end
      checks++; if (req_we_32 !== 1'b1) begin fails++; $display("FAIL sh_req_we[%0d] got=%b exp=1", i, req_we_32); end
      checks++; if (wstrb_32 !== 4'b1100) begin fails++; $display("FAIL sh_wstrb[%0d] got=%b exp=1100", i, wstrb_32); end
      checks++; if (req_wdata_32 !== 32'hABCD_0000) begin fails++; $display("FAIL sh_wdata[%0d] got=%h exp=abcd0000", i, req_wdata_32); end
      checks++; if (req_addr_32 !== 32'h2000) begin fails++; $display("FAIL sh_req_addr[%0d] got=%h exp=00002000", i, req_addr_32); end
      checks++; if (ex_ready_32 !== 1'b0) begin fails++; $display("FAIL sh_ex_ready_req[%0d] got=%b exp=0", i, ex_ready_32); end
      @(negedge clk);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      checks++; if (rsp_ready_32 !== 1'b1) begin fails++; $display("FAIL sh_rsp_ready[%0d] got=%b exp=1", i, rsp_ready_32); end
      checks++; if (ex_ready_32 !== 1'b0) begin fails++; $display("FAIL sh_ex_ready_wait[%0d] got=%b exp=0", i, ex_ready_32); end
      checks++; if (wb_valid_32 !== 1'b0) begin fails++; $display("FAIL sh_wb_early[%0d] got=%b exp=0", i, wb_valid_32); end
      if (i == 1) rsp_valid = 1'b1;
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    checks++; if (wb_valid_32 !== 1'b1) begin fails++; $display("FAIL sh_wb_valid got=%b exp=1", wb_valid_32); end
    checks++; if (wb_rf_we_32 !== 1'b0) begin fails++; $display("FAIL sh_wb_rf_we got=%b exp=0", wb_rf_we_32); end
    checks++; if (wb_data_32 !== 32'h0) begin fails++; $display("FAIL sh_wb_data got=%h exp=00000000", wb_data_32); end
    checks++; if (wb_fault_32 !== 1'b0) begin fails++; $display("FAIL sh_wb_fault got=%b exp=0", wb_fault_32); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [5];
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
    vals[3] = 32'h4444_0004; vals[4] = 32'h5555_0005;
    wb_ready = 1'b1; ex_op = MOP_NONE; ex_rf_we = 1'b1;
    ex_valid = 1'b1; ex_result = {32'h0, vals[0]}; ex_rd = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (wb_valid_32 !== 1'b1) begin fails++; $display("FAIL b2b_wb_valid[%0d] got=%b exp=1", i, wb_valid_32); end
      checks++; if (wb_data_32 !== vals[i]) begin fails++; $display("FAIL b2b_wb_data[%0d] got=%h exp=%h", i, wb_data_32, vals[i]); end
      checks++; if (ex_ready_32 !== 1'b1) begin fails++; $display("FAIL b2b_ex_ready[%0d] got=%b exp=1", i, ex_ready_32); end
      if (i < 2) begin ex_result = {32'h0, vals[i+1]}; ex_rd = 5'(i + 2); end
      else ex_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (wb_valid_32 !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%b exp=0", wb_valid_32); end
    ex_valid = 1'b1; ex_result = {32'h0, vals[3]};
    @(negedge clk);
    checks++; if (wb_data_32 !== vals[3]) begin fails++; $display("FAIL hold_first got=%h exp=%h", wb_data_32, vals[3]); end
    wb_ready = 1'b0; ex_result = {32'h0, vals[4]};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (wb_valid_32 !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, wb_valid_32); end
      checks++; if (wb_data_32 !== vals[3]) begin fails++; $display("FAIL hold_data[%0d] got=%h exp=%h", i, wb_data_32, vals[3]); end
      checks++; if (ex_ready_32 !== 1'b0) begin fails++; $display("FAIL hold_ex_ready[%0d] got=%b exp=0", i, ex_ready_32); end
    end
    wb_ready = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    checks++; if (wb_data_32 !== vals[4]) begin fails++; $display("FAIL hold_next got=%h exp=%h", wb_data_32, vals[4]); end
    @(negedge clk);
  endtask

  task automatic test_64bit();
    apply_reset();
    mem_load(MOP_LWU, 64'h4, 64'hF000_0000_0000_0000);
    checks++; if (wb_data_64 !== 64'h0000_0000_F000_0000) begin fails++; $display("FAIL lwu64_data got=%h exp=00000000f0000000", wb_data_64); end
    @(negedge clk);
    mem_load(MOP_LW, 64'h4, 64'hF000_0000_0000_0000);
    checks++; if (wb_data_64 !== 64'hFFFF_FFFF_F000_0000) begin fails++; $display("FAIL lw64_data got=%h exp=fffffffff0000000", wb_data_64); end
    @(negedge clk);
    issue(MOP_LD, 64'h8, 64'h0, 64'h0, 5'd4);
    checks++; if (wb_fault_32 !== 1'b1) begin fails++; $display("FAIL ld32_fault got=%b exp=1", wb_fault_32); end
    checks++; if (wb_data_32 !== 32'h8) begin fails++; $display("FAIL ld32_data got=%h exp=00000008", wb_data_32); end
    checks++; if (req_valid_32 !== 1'b0) begin fails++; $display("FAIL ld32_req_valid got=%b exp=0", req_valid_32); end
    checks++; if (req_valid_64 !== 1'b1) begin fails++; $display("FAIL ld64_req_valid got=%b exp=1", req_valid_64); end
    checks++; if (req_addr_64 !== 64'h8) begin fails++; $display("FAIL ld64_req_addr got=%h exp=8", req_addr_64); end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    rsp_valid = 1'b0;
    checks++; if (wb_data_64 !== 64'h1234_5678_9ABC_DEF0) begin fails++; $display("FAIL ld64_data got=%h exp=123456789abcdef0", wb_data_64); end
    checks++; if (wb_rf_we_64 !== 1'b1) begin fails++; $display("FAIL ld64_rf_we got=%b exp=1", wb_rf_we_64); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(MOP_LW, 64'h10, 64'h0, 64'h0, 5'd2);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    checks++; if (rsp_ready_32 !== 1'b1) begin fails++; $display("FAIL rmid_in_wait got=%b exp=1", rsp_ready_32); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (wb_valid_32 !== 1'b0) begin fails++; $display("FAIL rmid_wb_valid got=%b exp=0", wb_valid_32); end
    checks++; if (rsp_ready_32 !== 1'b0) begin fails++; $display("FAIL rmid_rsp_ready got=%b exp=0", rsp_ready_32); end
    checks++; if (ex_ready_32 !== 1'b1) begin fails++; $display("FAIL rmid_ex_ready got=%b exp=1", ex_ready_32); end
    mem_load(MOP_LW, 64'h20, 64'h0000_0000_DEAD_BEEF);
    checks++; if (wb_valid_32 !== 1'b1) begin fails++; $display("FAIL rmid_lw_valid got=%b exp=1", wb_valid_32); end
    checks++; if (wb_data_32 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rmid_lw_data got=%h exp=deadbeef", wb_data_32); end
    checks++; if (wb_rf_we_32 !== 1'b1) begin fails++; $display("FAIL rmid_lw_rf_we got=%b exp=1", wb_rf_we_32); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu();
    test_misaligned();
    test_store_stall();
    test_back_to_back();
    test_64bit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
